// File: rtl/stage_execute_md_if.sv
// Execute-stage bus: ID/EX inputs, EX/MEM register outputs, and hazard/redirect signals.
// The master side is the pipeline around the stage; the slave side is the execute stage.
interface stage_execute_md_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  ex_valid;
  logic                  ex_kill;
  logic                  mem_clear;
  logic                  mem_stall;
  logic                  ex_reg_write;
  logic                  ex_mem_write;
  logic                  ex_jump;
  logic                  ex_jump_cond;
  logic [2:0]            ex_jump_cond_type;
  logic [3:0]            ex_alu_control;
  logic                  ex_alu_src_op1;
  logic                  ex_alu_src_op2;
  logic                  ex_pc_target_src;
  logic [1:0]            ex_result_src;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_pc_plus_4;
  logic [XLEN-1:0]       ex_imm_ext;
  logic [XLEN-1:0]       ex_rd1;
  logic [XLEN-1:0]       ex_rd2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [XLEN-1:0]       wb_result;
  logic [1:0]            ex_op1_forward;
  logic [1:0]            ex_op2_forward;

  logic                  ex_stall;
  logic                  ex_pc_src;
  logic [XLEN-1:0]       ex_pc_target;
  logic                  mem_reg_write;
  logic                  mem_mem_write;
  logic [1:0]            mem_result_src;
  logic [XLEN-1:0]       mem_alu_result;
  logic [XLEN-1:0]       mem_write_data;
  logic [XLEN-1:0]       mem_pc_plus_4;
  logic [XLEN-1:0]       mem_imm_ext;
  logic [REG_ADDR_W-1:0] mem_rd;

  modport master (
    output ex_valid, ex_kill, mem_clear, mem_stall, ex_reg_write, ex_mem_write, ex_jump,
           ex_jump_cond, ex_jump_cond_type, ex_alu_control, ex_alu_src_op1, ex_alu_src_op2,
           ex_pc_target_src, ex_result_src, ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2,
           ex_rd, wb_result, ex_op1_forward, ex_op2_forward,
    input  ex_stall, ex_pc_src, ex_pc_target, mem_reg_write, mem_mem_write, mem_result_src,
           mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext, mem_rd
  );

  modport slave (
    input  ex_valid, ex_kill, mem_clear, mem_stall, ex_reg_write, ex_mem_write, ex_jump,
           ex_jump_cond, ex_jump_cond_type, ex_alu_control, ex_alu_src_op1, ex_alu_src_op2,
           ex_pc_target_src, ex_result_src, ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2,
           ex_rd, wb_result, ex_op1_forward, ex_op2_forward,
    output ex_stall, ex_pc_src, ex_pc_target, mem_reg_write, mem_mem_write, mem_result_src,
           mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext, mem_rd
  );
endinterface

// File: rtl/stage_execute_md.sv
// Execute stage: forwarding, ALU, branch resolution, EX/MEM register. Define EX_MULDIV_EN to
// add the iterative multiply/divide unit (MUL/DIVU/REMU) with its stall handshake.
module stage_execute_md #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic             clk,
  input logic             reset,
  stage_execute_md_if.slave bus
);
  localparam int unsigned ShW = $clog2(XLEN);
  localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluAnd = 4'd2, AluOr = 4'd3,
                         AluXor = 4'd4, AluSll = 4'd5, AluSrl = 4'd6, AluSra = 4'd7,
                         AluSlt = 4'd8, AluSltu = 4'd9, AluMul = 4'd12, AluDivu = 4'd13,
                         AluRemu = 4'd14;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op1, op2, alu_comb, alu_result;
  logic [ShW-1:0]  shamt;
  logic            taken, ex_stall;

  logic                  mem_reg_write_q, mem_mem_write_q;
  logic [1:0]            mem_result_src_q;
  logic [XLEN-1:0]       mem_alu_result_q, mem_write_data_q, mem_pc_plus_4_q, mem_imm_ext_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;

  always_comb begin
    case (bus.ex_op1_forward)
      2'b01:   fwd_rs1 = bus.wb_result;
      2'b10:   fwd_rs1 = mem_alu_result_q;
      default: fwd_rs1 = bus.ex_rd1;
    endcase
    case (bus.ex_op2_forward)
      2'b01:   fwd_rs2 = bus.wb_result;
      2'b10:   fwd_rs2 = mem_alu_result_q;
      default: fwd_rs2 = bus.ex_rd2;
    endcase
    op1   = bus.ex_alu_src_op1 ? fwd_rs1 : '0;
    op2   = bus.ex_alu_src_op2 ? bus.ex_imm_ext : fwd_rs2;
    shamt = op2[ShW-1:0];
  end

  always_comb begin
    case (bus.ex_alu_control)
      AluAdd:  alu_comb = op1 + op2;
      AluSub:  alu_comb = op1 - op2;
      AluAnd:  alu_comb = op1 & op2;
      AluOr:   alu_comb = op1 | op2;
      AluXor:  alu_comb = op1 ^ op2;
      AluSll:  alu_comb = op1 << shamt;
      AluSrl:  alu_comb = op1 >> shamt;
      AluSra:  alu_comb = $signed(op1) >>> shamt;
      AluSlt:  alu_comb = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      AluSltu: alu_comb = {{(XLEN-1){1'b0}}, op1 < op2};
      default: alu_comb = '0;
    endcase
  end

  // Branch compare sees forwarded rs1 against the op2 mux output.
  always_comb begin
    case (bus.ex_jump_cond_type)
      3'd0:    taken = (fwd_rs1 == op2);
      3'd1:    taken = (fwd_rs1 != op2);
      3'd4:    taken = ($signed(fwd_rs1) < $signed(op2));
      3'd5:    taken = !($signed(fwd_rs1) < $signed(op2));
      3'd6:    taken = (fwd_rs1 < op2);
      3'd7:    taken = !(fwd_rs1 < op2);
      default: taken = 1'b0;
    endcase
  end

`ifdef EX_MULDIV_EN
  localparam int unsigned CntW = (ShW > 0) ? ShW : 1;
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, acc_q, md_result;
  logic [XLEN:0]   div_sh, div_diff;
  logic            start, md_done;

  assign start = bus.ex_valid & ~bus.ex_kill &
                 ((bus.ex_alu_control == AluMul) | (bus.ex_alu_control == AluDivu) |
                  (bus.ex_alu_control == AluRemu));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StBusy;
      StBusy: begin
        if (bus.ex_kill)                     state_d = StIdle;
        else if (cnt_q == CntW'(XLEN - 1))   state_d = StDone;
      end
      StDone: if (bus.ex_kill || !bus.mem_stall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ex_stall = (state_q == StBusy) | ((state_q == StIdle) & start);
    md_done  = (state_q == StDone);
  end

  // Restoring divider: a_q shifts the dividend out and the quotient in; acc_q is the remainder.
  always_comb begin
    div_sh   = {acc_q, a_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (state_q == StIdle) begin
      if (start) begin
        cnt_q <= '0;
        op_q  <= bus.ex_alu_control;
        a_q   <= fwd_rs1;
        b_q   <= fwd_rs2;
        acc_q <= '0;
      end
    end else if (state_q == StBusy) begin
      cnt_q <= cnt_q + CntW'(1);
      if (op_q == AluMul) begin
        if (b_q[0]) acc_q <= acc_q + a_q;
        a_q <= a_q << 1;
        b_q <= b_q >> 1;
      end else if (!div_diff[XLEN]) begin
        acc_q <= div_diff[XLEN-1:0];
        a_q   <= {a_q[XLEN-2:0], 1'b1};
      end else begin
        acc_q <= div_sh[XLEN-1:0];
        a_q   <= {a_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign md_result  = (op_q == AluDivu) ? a_q : acc_q;
  assign alu_result = md_done ? md_result : alu_comb;
`else
  assign ex_stall   = 1'b0;
  assign alu_result = alu_comb;
`endif

  assign bus.ex_stall     = ex_stall;
  assign bus.ex_pc_target = bus.ex_pc_target_src ? alu_result : bus.ex_pc + bus.ex_imm_ext;
  assign bus.ex_pc_src    = bus.ex_valid & ~bus.ex_kill & ~ex_stall &
                            (bus.ex_jump | (bus.ex_jump_cond & taken));

  // A stalled EX loads a bubble: data fields are don't-care, only the write enables matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bus.mem_clear) begin
      mem_reg_write_q  <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_result_src_q <= '0;
      mem_alu_result_q <= '0;
      mem_write_data_q <= '0;
      mem_pc_plus_4_q  <= '0;
      mem_imm_ext_q    <= '0;
      mem_rd_q         <= '0;
    end else if (!bus.mem_stall) begin
      mem_reg_write_q  <= bus.ex_reg_write & bus.ex_valid & ~bus.ex_kill & ~ex_stall;
      mem_mem_write_q  <= bus.ex_mem_write & bus.ex_valid & ~bus.ex_kill & ~ex_stall;
      mem_result_src_q <= bus.ex_result_src;
      mem_alu_result_q <= alu_result;
      mem_write_data_q <= fwd_rs2;
      mem_pc_plus_4_q  <= bus.ex_pc_plus_4;
      mem_imm_ext_q    <= bus.ex_imm_ext;
      mem_rd_q         <= bus.ex_rd;
    end
  end

  assign bus.mem_reg_write  = mem_reg_write_q;
  assign bus.mem_mem_write  = mem_mem_write_q;
  assign bus.mem_result_src = mem_result_src_q;
  assign bus.mem_alu_result = mem_alu_result_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_pc_plus_4  = mem_pc_plus_4_q;
  assign bus.mem_imm_ext    = mem_imm_ext_q;
  assign bus.mem_rd         = mem_rd_q;
endmodule

// File: tb/tb_stage_execute_md.sv
// Self-checking bench for stage_execute_md; EX_MULDIV_EN selects the multiply/divide scenarios.
module tb_stage_execute_md;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_v;

  always #5 clk = ~clk;

  stage_execute_md_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

  stage_execute_md #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.ex_valid = 0; bus.ex_kill = 0; bus.mem_clear = 0; bus.mem_stall = 0;
    bus.ex_reg_write = 0; bus.ex_mem_write = 0; bus.ex_jump = 0; bus.ex_jump_cond = 0;
    bus.ex_jump_cond_type = 0; bus.ex_alu_control = 0; bus.ex_alu_src_op1 = 1;
    bus.ex_alu_src_op2 = 0; bus.ex_pc_target_src = 0; bus.ex_result_src = 0;
    bus.ex_pc = 0; bus.ex_pc_plus_4 = 0; bus.ex_imm_ext = 0; bus.ex_rd1 = 0; bus.ex_rd2 = 0;
    bus.ex_rd = 0; bus.wb_result = 0; bus.ex_op1_forward = 0; bus.ex_op2_forward = 0;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [XLEN-1:0] a, b,
                         input logic [RW-1:0] rd);
    set_idle();
    bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_alu_control = op;
    bus.ex_rd1 = a; bus.ex_rd2 = b; bus.ex_rd = rd;
  endtask

  task automatic test_reset();
    reset = 0;
    set_idle();
    #12;
    n_tests++;
    if ({bus.mem_reg_write, bus.mem_mem_write} !== 2'b00) begin
      n_fail++; $display("FAIL reset_we: got %b want 00", {bus.mem_reg_write, bus.mem_mem_write});
    end
    n_tests++;
    if (bus.mem_alu_result !== '0 || bus.mem_rd !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", bus.mem_alu_result, bus.mem_rd);
    end
    n_tests++;
    if (bus.ex_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", bus.ex_stall);
    end
    set_alu(4'd0, 32'd3, 32'd4, 5'd1);
    step();
    n_tests++;
    if (bus.mem_alu_result !== '0) begin
      n_fail++; $display("FAIL reset_hold: got %h want 0", bus.mem_alu_result);
    end
    reset = 1;
    set_idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0]      op [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0};
    logic [XLEN-1:0] a  [12] = '{32'd5, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'd1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF};
    logic [XLEN-1:0] b  [12] = '{32'd7, 32'd7, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
                                 32'h21, 32'd4, 32'd4, 32'd1, 32'd1, 32'd7, 32'd2};
    logic [XLEN-1:0] ex [12] = '{32'd12, 32'hFFFFFFFE, 32'h00F000F0, 32'hFFF0FFF0,
                                 32'hFF00FF00, 32'd2, 32'h08000000, 32'hF8000000, 32'd1,
                                 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 12; i++) begin
      set_alu(op[i], a[i], b[i], RW'(i + 1));
      exp_q.push_back(ex[i]);
      step();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (bus.mem_alu_result !== exp_v) begin
        n_fail++; $display("FAIL alu_op%0d: got %h want %h", op[i], bus.mem_alu_result, exp_v);
      end
      n_tests++;
      if (bus.mem_reg_write !== 1'b1 || bus.mem_rd !== RW'(i + 1)) begin
        n_fail++; $display("FAIL alu_ctl%0d: got we=%b rd=%0d want 1/%0d", i,
                           bus.mem_reg_write, bus.mem_rd, i + 1);
      end
    end
    set_idle();
    step();
  endtask

  task automatic test_forwarding();
    set_alu(4'd0, 32'd5, 32'd0, 5'd3);
    bus.ex_alu_src_op2 = 1; bus.ex_imm_ext = 32'd7; bus.ex_op1_forward = 2'b01;
    bus.wb_result = 32'd100;
    exp_q.push_back(32'd107);
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (bus.mem_alu_result !== exp_v || bus.mem_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL fwd_wb_op1: got %0d we=%b want %0d we=1", bus.mem_alu_result,
                         bus.mem_reg_write, exp_v);
    end
    bus.ex_op1_forward = 2'b10; bus.ex_imm_ext = 32'd3;
    exp_q.push_back(32'd110);
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (bus.mem_alu_result !== exp_v) begin
      n_fail++; $display("FAIL fwd_mem_op1: got %0d want %0d", bus.mem_alu_result, exp_v);
    end
    bus.ex_op1_forward = 2'b00; bus.ex_alu_src_op2 = 0; bus.ex_op2_forward = 2'b01;
    bus.ex_rd2 = 32'd9;
    exp_q.push_back(32'd105);
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (bus.mem_alu_result !== exp_v || bus.mem_write_data !== 32'd100) begin
      n_fail++; $display("FAIL fwd_wb_op2: got %0d/%0d want %0d/100", bus.mem_alu_result,
                         bus.mem_write_data, exp_v);
    end
    bus.ex_op2_forward = 2'b10; bus.ex_alu_src_op2 = 1; bus.ex_imm_ext = 32'd1;
    bus.ex_pc_plus_4 = 32'h44;
    exp_q.push_back(32'd6);
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (bus.mem_alu_result !== exp_v || bus.mem_write_data !== 32'd105) begin
      n_fail++; $display("FAIL fwd_mem_op2: got %0d/%0d want %0d/105", bus.mem_alu_result,
                         bus.mem_write_data, exp_v);
    end
    n_tests++;
    if (bus.mem_imm_ext !== 32'd1 || bus.mem_pc_plus_4 !== 32'h44) begin
      n_fail++; $display("FAIL pass_fields: got %h/%h want 1/44", bus.mem_imm_ext,
                         bus.mem_pc_plus_4);
    end
    set_idle();
    step();
  endtask

  task automatic test_branch();
    logic [2:0]      ty [8] = '{4, 6, 5, 7, 0, 1, 2, 4};
    logic [XLEN-1:0] r2 [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd1, 32'd1};
    logic            kl [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic            ex [8] = '{1, 0, 0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      set_idle();
      bus.ex_valid = 1; bus.ex_jump_cond = 1; bus.ex_jump_cond_type = ty[i];
      bus.ex_kill = kl[i]; bus.ex_rd1 = 32'hFFFFFFFF; bus.ex_rd2 = r2[i];
      bus.ex_pc = 32'h100; bus.ex_imm_ext = 32'h20;
      #1;
      n_tests++;
      if (bus.ex_pc_src !== ex[i]) begin
        n_fail++; $display("FAIL branch%0d_type%0d: got %b want %b", i, ty[i], bus.ex_pc_src,
                           ex[i]);
      end
      if (i == 0) begin
        n_tests++;
        if (bus.ex_pc_target !== 32'h120) begin
          n_fail++; $display("FAIL branch_target: got %h want 120", bus.ex_pc_target);
        end
      end
    end
    set_idle();
    bus.ex_valid = 1; bus.ex_jump = 1; bus.ex_pc = 32'hFFFFFFF0; bus.ex_imm_ext = 32'h20;
    #1;
    n_tests++;
    if (bus.ex_pc_src !== 1'b1 || bus.ex_pc_target !== 32'h10) begin
      n_fail++; $display("FAIL jal_wrap: got %b/%h want 1/10", bus.ex_pc_src, bus.ex_pc_target);
    end
    bus.ex_pc_target_src = 1; bus.ex_alu_src_op2 = 1; bus.ex_rd1 = 32'h200;
    bus.ex_imm_ext = 32'h8;
    #1;
    n_tests++;
    if (bus.ex_pc_target !== 32'h208) begin
      n_fail++; $display("FAIL jalr_target: got %h want 208", bus.ex_pc_target);
    end
    set_idle();
    step();
  endtask

  task automatic test_pipe_ctrl();
    set_alu(4'd0, 32'd1, 32'd2, 5'd4);
    bus.ex_mem_write = 1;
    exp_q.push_back(32'd3);
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (bus.mem_alu_result !== exp_v || {bus.mem_reg_write, bus.mem_mem_write} !== 2'b11) begin
      n_fail++; $display("FAIL load: got %0d we=%b%b want %0d we=11", bus.mem_alu_result,
                         bus.mem_reg_write, bus.mem_mem_write, exp_v);
    end
    set_alu(4'd0, 32'd10, 32'd10, 5'd5);
    bus.mem_stall = 1;
    repeat (2) begin
      step();
      n_tests++;
      if (bus.mem_alu_result !== 32'd3 || bus.mem_rd !== 5'd4) begin
        n_fail++; $display("FAIL mem_stall_hold: got %0d rd=%0d want 3 rd=4",
                           bus.mem_alu_result, bus.mem_rd);
      end
    end
    bus.mem_stall = 0;
    exp_q.push_back(32'd20);
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (bus.mem_alu_result !== exp_v) begin
      n_fail++; $display("FAIL stall_release: got %0d want %0d", bus.mem_alu_result, exp_v);
    end
    bus.ex_valid = 0; bus.ex_mem_write = 1;
    step();
    n_tests++;
    if ({bus.mem_reg_write, bus.mem_mem_write} !== 2'b00) begin
      n_fail++; $display("FAIL invalid_load: got %b%b want 00", bus.mem_reg_write,
                         bus.mem_mem_write);
    end
    bus.ex_valid = 1; bus.ex_kill = 1;
    step();
    n_tests++;
    if ({bus.mem_reg_write, bus.mem_mem_write} !== 2'b00) begin
      n_fail++; $display("FAIL kill_load: got %b%b want 00", bus.mem_reg_write,
                         bus.mem_mem_write);
    end
    bus.ex_kill = 0; bus.mem_stall = 1; bus.mem_clear = 1; bus.ex_result_src = 2'b11;
    step();
    n_tests++;
    if ({bus.mem_reg_write, bus.mem_mem_write, bus.mem_result_src, bus.mem_alu_result,
         bus.mem_write_data, bus.mem_rd} !== '0) begin
      n_fail++; $display("FAIL mem_clear: got we=%b res=%h wd=%h rd=%0d want all 0",
                         bus.mem_reg_write, bus.mem_alu_result, bus.mem_write_data, bus.mem_rd);
    end
    set_idle();
    step();
  endtask

`ifdef EX_MULDIV_EN
  task automatic run_muldiv(input string name, input logic [3:0] op,
                            input logic [XLEN-1:0] a, b, res, input int hold_n);
    int edges = 0;
    int stalls = 0;
    int holds = 0;
    bit got = 0;
    set_alu(op, a, b, 5'd9);
    exp_q.push_back(res);
    while (!got && edges < 100) begin
      #1;
      if (bus.ex_stall) stalls++;
      if (!bus.ex_stall && holds < hold_n) begin
        bus.mem_stall = 1; holds++;
      end else begin
        bus.mem_stall = 0;
      end
      step();
      edges++;
      if (bus.mem_reg_write) got = 1;
    end
    set_idle();
    n_tests++;
    if (edges !== 34 + hold_n) begin
      n_fail++; $display("FAIL %s_latency: got %0d edges want %0d", name, edges, 34 + hold_n);
    end
    n_tests++;
    if (stalls !== 33) begin
      n_fail++; $display("FAIL %s_stall_cycles: got %0d want 33", name, stalls);
    end
    exp_v = exp_q.pop_front();
    n_tests++;
    if (bus.mem_alu_result !== exp_v || !got) begin
      n_fail++; $display("FAIL %s_result: got %h want %h", name, bus.mem_alu_result, exp_v);
    end
    step();
  endtask

  task automatic test_muldiv();
    run_muldiv("mul_6x7", 4'd12, 32'd6, 32'd7, 32'd42, 0);
    run_muldiv("mul_wrap", 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 0);
    run_muldiv("divu_by0", 4'd13, 32'd100, 32'd0, 32'hFFFFFFFF, 0);
    run_muldiv("remu_by0", 4'd14, 32'd100, 32'd0, 32'd100, 0);
    run_muldiv("remu_100_7", 4'd14, 32'd100, 32'd7, 32'd2, 0);
    run_muldiv("divu_hold", 4'd13, 32'd100, 32'd7, 32'd14, 3);
  endtask

  task automatic test_kill();
    int writes = 0;
    set_alu(4'd12, 32'd6, 32'd7, 5'd9);
    repeat (5) step();
    bus.ex_kill = 1;
    step();
    n_tests++;
    if (bus.ex_stall !== 1'b0) begin
      n_fail++; $display("FAIL kill_stall: got %b want 0", bus.ex_stall);
    end
    set_idle();
    repeat (40) begin
      step();
      if (bus.mem_reg_write) writes++;
    end
    n_tests++;
    if (writes !== 0) begin
      n_fail++; $display("FAIL kill_writeback: got %0d writes want 0", writes);
    end
  endtask
`else
  task automatic test_muldiv_disabled();
    for (int op = 12; op <= 14; op++) begin
      set_alu(4'(op), 32'd100, 32'd7, 5'd2);
      exp_q.push_back(32'd0);
      #1;
      n_tests++;
      if (bus.ex_stall !== 1'b0) begin
        n_fail++; $display("FAIL md_off_stall%0d: got %b want 0", op, bus.ex_stall);
      end
      step();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (bus.mem_alu_result !== exp_v || bus.mem_reg_write !== 1'b1) begin
        n_fail++; $display("FAIL md_off_result%0d: got %h we=%b want %h we=1", op,
                           bus.mem_alu_result, bus.mem_reg_write, exp_v);
      end
    end
    set_idle();
    step();
  endtask
`endif

  task automatic test_reset_mid();
    set_alu(4'd0, 32'd2, 32'd2, 5'd7);
    step();
`ifdef EX_MULDIV_EN
    set_alu(4'd12, 32'd6, 32'd7, 5'd9);
    repeat (5) step();
`endif
    #3;
    reset = 0;
    bus.ex_valid = 0;
    #1;
    n_tests++;
    if ({bus.mem_reg_write, bus.mem_mem_write, bus.mem_result_src, bus.mem_alu_result,
         bus.mem_write_data, bus.mem_pc_plus_4, bus.mem_imm_ext, bus.mem_rd} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got res=%h wd=%h rd=%0d want all 0",
                         bus.mem_alu_result, bus.mem_write_data, bus.mem_rd);
    end
    n_tests++;
    if (bus.ex_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_stall: got %b want 0", bus.ex_stall);
    end
    step();
    reset = 1;
    set_alu(4'd0, 32'd2, 32'd3, 5'd1);
    exp_q.push_back(32'd5);
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (bus.mem_alu_result !== exp_v || bus.mem_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL after_reset: got %0d we=%b want %0d we=1", bus.mem_alu_result,
                         bus.mem_reg_write, exp_v);
    end
    set_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_forwarding();
    test_branch();
    test_pipe_ctrl();
`ifdef EX_MULDIV_EN
    test_muldiv();
    test_kill();
`else
    test_muldiv_disabled();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
